// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store, one transaction at a time.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternate grants on a tie instead of data-over-fetch priority).
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    state_t             state, state_nx;
    owner_t             owner, owner_nx;
    logic [CNT_W-1:0]   lat_cnt, lat_cnt_nx;
    logic               pick_d;

    // owner doubles as the last-owner history for the tie-break
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && if_req)
            pick_d = (owner == OWN_IF);
        else
            pick_d = d_req;
`else
        pick_d = d_req;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= OWN_IF;
            lat_cnt <= '0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            lat_cnt <= lat_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        lat_cnt_nx = lat_cnt;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    mem_en     = 1'b1;
                    state_nx   = BUSY;
                    lat_cnt_nx = CNT_W'(MEM_LAT);
                    if (pick_d) begin
                        d_gnt     = 1'b1;
                        owner_nx  = OWN_D;
                        mem_we    = d_we;
                        mem_be    = d_be;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                    end else begin
                        if_gnt    = 1'b1;
                        owner_nx  = OWN_IF;
                        mem_be    = '1;
                        mem_addr  = if_addr;
                    end
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (lat_cnt != '0)
                    lat_cnt_nx = lat_cnt - CNT_W'(1);
                if (lat_cnt == CNT_W'(1)) begin
                    if (owner == OWN_D)
                        d_rvalid = 1'b1;
                    else
                        if_rvalid = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-vector table plus hand sequences, with an rvalid/rdata scoreboard.
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clk, rst_n;
    logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
    logic        mem_en, mem_we, busy;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  d_be, mem_be;

    logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_d_be, a_mem_be;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
        .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    typedef struct packed {
        logic        ig, dg, en, we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic        bsy;
    } out_t;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr, dwe;
        logic [3:0]  dbe;
        logic [31:0] da, dwd;
        out_t        exp;
    } vec_t;

    typedef struct {
        logic        own_d;
        int          due;
        logic [31:0] data;
        logic        chk;
    } sb_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    sb_t  q[$];
    vec_t tbl[22];
    logic [31:0] stg[LAT];
    logic [31:0] a_stg;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // memory models: read data for an address appears exactly LAT cycles after mem_en
    always @(posedge clk) begin
        stg[0] <= (mem_en && !mem_we) ? mdata(mem_addr) : 32'h0BAD_F00D;
        for (int unsigned i = 1; i < LAT; i++) stg[i] <= stg[i-1];
        a_stg <= (a_mem_en && !a_mem_we) ? mdata(a_mem_addr) : 32'h0BAD_F00D;
    end
    assign mem_rdata   = stg[LAT-1];
    assign a_mem_rdata = a_stg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic out_t sample();
        return {if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, busy};
    endfunction

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                                input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
                                input logic ig, input logic dg, input logic we, input logic [3:0] be,
                                input logic [31:0] ma, input logic bsy);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.dbe = dbe; v.da = da; v.dwd = dwd;
        v.exp = {ig, dg, ig | dg, we, be, ma, bsy};
        return v;
    endfunction

    function automatic vec_t bz(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
        return mk(ir, ia, dr, 1'b0, 4'hF, da, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    endfunction

    task automatic push(input logic own_d, input logic [31:0] addr, input logic chk);
        q.push_back('{own_d, cyc + LAT, mdata(addr), chk});
    endtask

    // every cycle: rvalid must be exactly the scoreboard's due owner, with the right data
    always @(negedge clk) begin
        logic [1:0]  exp_rv;
        logic [31:0] exp_d;
        logic        chk_d;
        exp_rv = 2'b00;
        exp_d  = '0;
        chk_d  = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv = q[0].own_d ? 2'b01 : 2'b10;
            exp_d  = q[0].data;
            chk_d  = q[0].chk;
            void'(q.pop_front());
        end
        check("rvalid", {62'b0, if_rvalid, d_rvalid}, {62'b0, exp_rv});
        if (chk_d)
            check("rdata", exp_rv[1] ? if_rdata : d_rdata, exp_d);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] eg;
        rst_n = 1'b0;
        {if_req, d_req, d_we} = '0; if_addr = '0; d_be = '0; d_addr = '0; d_wdata = '0;
        {a_if_req, a_d_req, a_d_we} = '0; a_if_addr = '0; a_d_be = '0; a_d_addr = '0; a_d_wdata = '0;

        tbl[0]  = mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        tbl[1]  = mk(1, 32'h100, 0, 0, 4'h0, 0, 0, 1, 0, 0, 4'hF, 32'h100, 0);
        tbl[2]  = bz(0, 0, 0, 0);
        tbl[3]  = bz(0, 0, 0, 0);
        tbl[4]  = bz(0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 1, 1, 4'h3, 32'h200, 0);
        tbl[6]  = bz(1, 32'h104, 0, 0);
        tbl[7]  = bz(1, 32'h104, 0, 0);
        tbl[8]  = bz(1, 32'h104, 0, 0);
        tbl[9]  = mk(1, 32'h104, 0, 0, 4'h0, 0, 0, 1, 0, 0, 4'hF, 32'h104, 0);
        tbl[10] = bz(0, 0, 1, 32'h300);
        tbl[11] = bz(0, 0, 1, 32'h300);
        tbl[12] = bz(0, 0, 1, 32'h300);
        tbl[13] = mk(1, 32'h108, 1, 0, 4'hF, 32'h300, 0, 0, 1, 0, 4'hF, 32'h300, 0);
        tbl[14] = bz(1, 32'h108, 0, 0);
        tbl[15] = bz(1, 32'h108, 0, 0);
        tbl[16] = bz(1, 32'h108, 0, 0);
        tbl[17] = mk(1, 32'h108, 0, 0, 4'h0, 0, 0, 1, 0, 0, 4'hF, 32'h108, 0);
        tbl[18] = bz(0, 0, 0, 0);
        tbl[19] = bz(0, 0, 0, 0);
        tbl[20] = bz(0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0);

        @(negedge clk);
        check("reset_outputs", 64'(sample()), 64'h0);
        check("reset_l1", {60'b0, a_if_gnt, a_d_gnt, a_mem_en, a_busy}, 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // cycle vectors: fetch, store, fetch waiting behind store, load, tie, fetch
        for (int unsigned i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            if_req = tbl[i].ir; if_addr = tbl[i].ia;
            d_req = tbl[i].dr; d_we = tbl[i].dwe; d_be = tbl[i].dbe; d_addr = tbl[i].da; d_wdata = tbl[i].dwd;
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(sample()), 64'(tbl[i].exp));
            if (tbl[i].exp.we)
                check($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].dwd);
            if (tbl[i].exp.ig || tbl[i].exp.dg)
                push(tbl[i].exp.dg, tbl[i].exp.addr, !tbl[i].exp.we);
        end

        // reset in the middle of a fetch: its rvalid must never appear
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h400; d_req = 1'b0;
        @(negedge clk);
        check("rst_grant", 64'(sample()), 64'({1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h400, 1'b0}));
        push(1'b0, 32'h400, 1'b1);
        @(posedge clk); #1 if_req = 1'b0; rst_n = 1'b0; q.delete();
        @(negedge clk);
        check("rst_mid_busy", 64'(sample()), 64'h0);
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_held", 64'(sample()), 64'h0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_after", 64'(sample()), 64'h0);
            @(posedge clk); #1;
        end
        if_req = 1'b1; if_addr = 32'h404;
        @(negedge clk);
        check("rst_regrant", 64'(sample()), 64'({1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h404, 1'b0}));
        push(1'b0, 32'h404, 1'b1);
        @(posedge clk); #1 if_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // both requesters held high continuously
        for (int unsigned k = 0; k < 16; k++) begin
            if_req = 1'b1; if_addr = 32'h600;
            d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h500;
            @(negedge clk);
            eg = 2'b00;
            if (k % 4 == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                eg = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
`else
                eg = 2'b01;
`endif
            end
            check($sformatf("tie%0d", k), {61'b0, if_gnt, d_gnt, busy}, {61'b0, eg, (k % 4 != 0)});
            if (eg != 2'b00)
                push(eg[0], eg[0] ? 32'h500 : 32'h600, 1'b1);
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("tie_idle", 64'(sample()), 64'h0);
            @(posedge clk); #1;
        end
        check("sb_empty", 64'(q.size()), 64'h0);

        // MEM_LAT=1 instance: back-to-back fetches, one per two cycles
        a_if_req = 1'b1; a_if_addr = 32'h100;
        @(negedge clk);
        check("l1_grant", {a_if_gnt, a_mem_en, a_busy, a_mem_addr}, {1'b1, 1'b1, 1'b0, 32'h100});
        @(posedge clk); #1 a_if_req = 1'b0;
        @(negedge clk);
        check("l1_rvalid", {a_if_rvalid, a_d_rvalid, a_if_gnt, a_busy}, 4'b1001);
        check("l1_rdata", a_if_rdata, mdata(32'h100));
        @(posedge clk); #1 a_if_req = 1'b1; a_if_addr = 32'h104;
        @(negedge clk);
        check("l1_grant2", {a_if_gnt, a_mem_en, a_busy, a_mem_addr}, {1'b1, 1'b1, 1'b0, 32'h104});
        @(posedge clk); #1 a_if_req = 1'b0;
        @(negedge clk);
        check("l1_rvalid2", {a_if_rvalid, a_d_rvalid, a_if_gnt, a_busy}, 4'b1001);
        check("l1_rdata2", a_if_rdata, mdata(32'h104));
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_idle", {a_if_rvalid, a_d_rvalid, a_mem_en, a_busy}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
